// File: rtl/ms_pkg.sv
// Shared Minesweeper definitions: default board size, cursor FSM states and
// the helper that turns a cell count into a coordinate width.
package ms_pkg;

    localparam int DEF_COLS = 8;
    localparam int DEF_ROWS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int calc_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_xw(input int cols);
        return calc_w(cols);
    endfunction

    function automatic int calc_yw(input int rows);
        return calc_w(rows);
    endfunction

endpackage

// File: rtl/blink_div.sv
// Terminal-count divider: toggles blink once every DIV clock cycles.
module blink_div #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic blink
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// Grid cursor for the Minesweeper board: moves on debounced button pulses,
// issues reveal requests over a req/ack handshake and drives the blink phase.
module cursor_ctrl
    import ms_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int WRAP      = 1,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_valid,
    input  logic                      down_valid,
    input  logic                      left_valid,
    input  logic                      right_valid,
    input  logic                      center_valid,
    input  logic                      game_over,
    input  logic                      reveal_ack,
    output logic [calc_xw(COLS)-1:0]  cur_x,
    output logic [calc_yw(ROWS)-1:0]  cur_y,
    output logic                      reveal_req,
    output logic [calc_xw(COLS)-1:0]  reveal_x,
    output logic [calc_yw(ROWS)-1:0]  reveal_y,
    output logic                      blink
);

    localparam int XW = calc_xw(COLS);
    localparam int YW = calc_yw(ROWS);
    localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
    localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

    state_t        state_q;
    state_t        state_nx;
    logic [XW-1:0] cur_x_nx;
    logic [YW-1:0] cur_y_nx;
    logic [XW-1:0] reveal_x_nx;
    logic [YW-1:0] reveal_y_nx;

    // Opposing presses cancel; the edge is COLS-1, not the all-ones value.
    function automatic logic [XW-1:0] step_x(input logic [XW-1:0] v,
                                             input logic inc, input logic dec);
        logic [XW-1:0] r;
        r = v;
        if (inc && !dec)
            r = (v == XMAX) ? ((WRAP != 0) ? '0 : XMAX) : v + XW'(1);
        else if (dec && !inc)
            r = (v == '0) ? ((WRAP != 0) ? XMAX : '0) : v - XW'(1);
        return r;
    endfunction

    function automatic logic [YW-1:0] step_y(input logic [YW-1:0] v,
                                             input logic inc, input logic dec);
        logic [YW-1:0] r;
        r = v;
        if (inc && !dec)
            r = (v == YMAX) ? ((WRAP != 0) ? '0 : YMAX) : v + YW'(1);
        else if (dec && !inc)
            r = (v == '0) ? ((WRAP != 0) ? YMAX : '0) : v - YW'(1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (game_over) begin
            state_nx = ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (center_valid) state_nx = ST_REQ;
                ST_REQ:  if (reveal_ack)   state_nx = ST_IDLE;
                ST_DONE: if (center_valid) state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_x_nx    = cur_x;
        cur_y_nx    = cur_y;
        reveal_x_nx = reveal_x;
        reveal_y_nx = reveal_y;
        unique case (state_q)
            ST_IDLE, ST_REQ: begin
                cur_x_nx = step_x(cur_x, right_valid, left_valid);
                cur_y_nx = step_y(cur_y, down_valid, up_valid);
                // Request carries the position seen before this cycle's move.
                if (state_q == ST_IDLE && state_nx == ST_REQ) begin
                    reveal_x_nx = cur_x;
                    reveal_y_nx = cur_y;
                end
            end
            ST_DONE: begin
                if (state_nx == ST_IDLE) begin
                    cur_x_nx = '0;
                    cur_y_nx = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_x      <= '0;
            cur_y      <= '0;
            reveal_x   <= '0;
            reveal_y   <= '0;
            reveal_req <= 1'b0;
        end else begin
            cur_x      <= cur_x_nx;
            cur_y      <= cur_y_nx;
            reveal_x   <= reveal_x_nx;
            reveal_y   <= reveal_y_nx;
            reveal_req <= (state_nx == ST_REQ);
        end
    end

    blink_div #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .blink (blink)
    );

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: three builds (8x8 wrap, 8x8 saturate, 5-wide wrap)
// share one directed stimulus and are checked against a rule-level model.
module tb_cursor_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_DONE = 2;
    localparam int DIV    = 4;

    typedef struct {
        int x; int y; int rx; int ry; int req; int st; int cnt; int blink;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic up_v = 1'b0, down_v = 1'b0, left_v = 1'b0, right_v = 1'b0;
    logic center_v = 1'b0, game_over = 1'b0, ack = 1'b0;

    logic [2:0] w_x, w_y, w_rx, w_ry, s_x, s_y, s_rx, s_ry, f_x, f_y, f_rx, f_ry;
    logic       w_req, w_bl, s_req, s_bl, f_req, f_bl;

    int checks = 0;
    int errors = 0;

    model_t m_w, m_s, m_f;

    always #5 clk = ~clk;

    cursor_ctrl #(.COLS(8), .ROWS(8), .WRAP(1), .BLINK_DIV(DIV)) dut_w (
        .clk(clk), .rst(rst), .up_valid(up_v), .down_valid(down_v),
        .left_valid(left_v), .right_valid(right_v), .center_valid(center_v),
        .game_over(game_over), .reveal_ack(ack), .cur_x(w_x), .cur_y(w_y),
        .reveal_req(w_req), .reveal_x(w_rx), .reveal_y(w_ry), .blink(w_bl));

    cursor_ctrl #(.COLS(8), .ROWS(8), .WRAP(0), .BLINK_DIV(DIV)) dut_s (
        .clk(clk), .rst(rst), .up_valid(up_v), .down_valid(down_v),
        .left_valid(left_v), .right_valid(right_v), .center_valid(center_v),
        .game_over(game_over), .reveal_ack(ack), .cur_x(s_x), .cur_y(s_y),
        .reveal_req(s_req), .reveal_x(s_rx), .reveal_y(s_ry), .blink(s_bl));

    cursor_ctrl #(.COLS(5), .ROWS(8), .WRAP(1), .BLINK_DIV(DIV)) dut_f (
        .clk(clk), .rst(rst), .up_valid(up_v), .down_valid(down_v),
        .left_valid(left_v), .right_valid(right_v), .center_valid(center_v),
        .game_over(game_over), .reveal_ack(ack), .cur_x(f_x), .cur_y(f_y),
        .reveal_req(f_req), .reveal_x(f_rx), .reveal_y(f_ry), .blink(f_bl));

    // One axis move on an n-cell line, wrapping modulo n or clamping.
    function automatic int mv(input int v, input int dlt, input int n, input int wrap);
        int t;
        t = v + dlt;
        if (wrap != 0) return (t + n) % n;
        if (t < 0) return 0;
        if (t > n - 1) return n - 1;
        return t;
    endfunction

    function automatic model_t mstep(input model_t m, input int cols, input int rows,
                                     input int wrap, input logic u, input logic d,
                                     input logic l, input logic r, input logic c,
                                     input logic go, input logic a);
        model_t n;
        n = m;
        if (m.cnt == DIV - 1) begin
            n.cnt   = 0;
            n.blink = 1 - m.blink;
        end else begin
            n.cnt = m.cnt + 1;
        end
        if (m.st != S_DONE) begin
            n.x = mv(m.x, (r ? 1 : 0) - (l ? 1 : 0), cols, wrap);
            n.y = mv(m.y, (d ? 1 : 0) - (u ? 1 : 0), rows, wrap);
        end
        if (go) begin
            n.st = S_DONE;
        end else if (m.st == S_IDLE && c) begin
            n.st = S_REQ;
            n.rx = m.x;
            n.ry = m.y;
        end else if (m.st == S_REQ && a) begin
            n.st = S_IDLE;
        end else if (m.st == S_DONE && c) begin
            n.st = S_IDLE;
            n.x  = 0;
            n.y  = 0;
        end
        n.req = (n.st == S_REQ) ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_w <= '{default: 0};
            m_s <= '{default: 0};
            m_f <= '{default: 0};
        end else begin
            m_w <= mstep(m_w, 8, 8, 1, up_v, down_v, left_v, right_v, center_v, game_over, ack);
            m_s <= mstep(m_s, 8, 8, 0, up_v, down_v, left_v, right_v, center_v, game_over, ack);
            m_f <= mstep(m_f, 5, 8, 1, up_v, down_v, left_v, right_v, center_v, game_over, ack);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input model_t m, input int x, input int y,
                       input int req, input int rx, input int ry, input int bl);
        chk({tag, ".cur_x"}, x, m.x);
        chk({tag, ".cur_y"}, y, m.y);
        chk({tag, ".reveal_req"}, req, m.req);
        chk({tag, ".blink"}, bl, m.blink);
        if (m.req != 0) begin
            chk({tag, ".reveal_x"}, rx, m.rx);
            chk({tag, ".reveal_y"}, ry, m.ry);
        end
    endtask

    always @(negedge clk) begin
        cmp("w", m_w, int'(w_x), int'(w_y), int'(w_req), int'(w_rx), int'(w_ry), int'(w_bl));
        cmp("s", m_s, int'(s_x), int'(s_y), int'(s_req), int'(s_rx), int'(s_ry), int'(s_bl));
        cmp("f", m_f, int'(f_x), int'(f_y), int'(f_req), int'(f_rx), int'(f_ry), int'(f_bl));
    end

    // Drive one cycle of pulses from a negedge, clear them at the next negedge.
    task automatic cyc(input logic u, input logic d, input logic l, input logic r,
                       input logic c, input logic a);
        up_v = u; down_v = d; left_v = l; right_v = r; center_v = c; ack = a;
        @(negedge clk);
        up_v = 0; down_v = 0; left_v = 0; right_v = 0; center_v = 0; ack = 0;
    endtask

    int exp_wrap[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int exp_sat[8]  = '{1, 2, 3, 4, 5, 6, 7, 7};
    int exp_five[8] = '{1, 2, 3, 4, 0, 1, 2, 3};
    int exp_blink[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cur_x", int'(w_x), 0);
        chk("rst_req", int'(w_req), 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("right_wrap8", int'(w_x), exp_wrap[i]);
            chk("right_sat8", int'(s_x), exp_sat[i]);
            chk("right_wrap5", int'(f_x), exp_five[i]);
        end

        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        chk("at33_x", int'(w_x), 3);
        chk("at33_y", int'(w_y), 3);
        cyc(1, 1, 0, 1, 0, 0);
        chk("updown_right_x", int'(w_x), 4);
        chk("updown_right_y", int'(w_y), 3);

        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("up_wrap_y", int'(w_y), 7);

        repeat (2) cyc(0, 0, 1, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("center_req", int'(w_req), 1);
        chk("center_rx", int'(w_rx), 2);
        chk("center_ry", int'(w_ry), 5);
        chk("center_move_x", int'(w_x), 3);
        chk("center_move_y", int'(w_y), 5);

        cyc(0, 0, 0, 0, 0, 0);
        chk("req_hold1", int'(w_req), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("req_hold2", int'(w_req), 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("req_hold3", int'(w_req), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ack_drop", int'(w_req), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("no_queue", int'(w_req), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("second_req", int'(w_req), 1);
        chk("second_rx", int'(w_rx), 3);

        game_over = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        game_over = 1'b0;
        chk("go_abort", int'(w_req), 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("done_frozen", int'(w_x), 3);
        cyc(0, 0, 0, 0, 1, 0);
        chk("restart_x", int'(w_x), 0);
        chk("restart_y", int'(w_y), 0);
        chk("restart_req", int'(w_req), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("restart_idle", int'(w_req), 0);

        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("pre_rst_req", int'(w_req), 1);
        chk("pre_rst_rx", int'(w_rx), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", int'(w_req), 0);
        chk("arst_x", int'(w_x), 0);
        chk("arst_y", int'(w_y), 0);
        chk("arst_rx", int'(w_rx), 0);
        chk("arst_blink", int'(w_bl), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("blink_seq", int'(w_bl), exp_blink[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
